// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: data/index widths, writeback source encodings and
// condition-code bit positions.
package lc3_pkg;

  localparam int LC3_DW    = 16;
  localparam int LC3_NREGS = 8;
  localparam int LC3_AW    = 3;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  // Exactly one of N/Z/P is set for any value.
  function automatic logic [2:0] lc3_nzp(input logic [LC3_DW-1:0] v);
    logic [2:0] cc;
    cc        = 3'b000;
    cc[PSR_N] = v[LC3_DW-1];
    cc[PSR_Z] = (v == '0);
    cc[PSR_P] = ~v[LC3_DW-1] & (v != '0);
    return cc;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// Eight 16-bit general-purpose registers: one synchronous write port,
// two asynchronous read ports, synchronous clear.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [LC3_AW-1:0] waddr,
  input  logic [LC3_DW-1:0] wdata,
  input  logic [LC3_AW-1:0] raddr1,
  input  logic [LC3_AW-1:0] raddr2,
  output logic [LC3_DW-1:0] rdata1,
  output logic [LC3_DW-1:0] rdata2
);

  logic [LC3_DW-1:0] regs_q [LC3_NREGS];
  logic [LC3_DW-1:0] regs_d [LC3_NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LC3_NREGS; gi++) begin : g_reg
      always_ff @(posedge clock) begin
        if (reset) regs_q[gi] <= '0;
        else       regs_q[gi] <= regs_d[gi];
      end
    end
  endgenerate

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: result select, register-file commit, NZP update and
// operand reads for Execute. Define LC3_WRITEBACK_BYPASS_EN for write-through reads.
module lc3_writeback
  import lc3_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [LC3_DW-1:0] aluout,
  input  logic [LC3_DW-1:0] pcout,
  input  logic [LC3_DW-1:0] memout,
  input  logic [LC3_AW-1:0] dr,
  input  logic [LC3_AW-1:0] sr1,
  input  logic [LC3_AW-1:0] sr2,
  output logic [LC3_DW-1:0] VSR1,
  output logic [LC3_DW-1:0] VSR2,
  output logic [2:0]        psr
);

  logic [LC3_DW-1:0] dr_in;
  logic              commit;
  logic [2:0]        psr_q, psr_d;
  logic [LC3_DW-1:0] rf_rd1, rf_rd2;

  always_comb begin
    dr_in = aluout;
    case (wb_sel_e'(W_Control))
      WB_ALU:  dr_in = aluout;
      WB_MEM:  dr_in = memout;
      WB_PC:   dr_in = pcout;
      default: dr_in = aluout;
    endcase
  end

  assign commit = enable_writeback && (wb_sel_e'(W_Control) != WB_NONE);

  always_comb begin
    psr_d = psr_q;
    if (commit) psr_d = lc3_nzp(dr_in);
  end

  always_ff @(posedge clock) begin
    if (reset) psr_q <= 3'b000;
    else       psr_q <= psr_d;
  end

  assign psr = psr_q;

  lc3_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (commit),
    .waddr  (dr),
    .wdata  (dr_in),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

`ifdef LC3_WRITEBACK_BYPASS_EN
  // Forward the value being committed so Execute needn't stall on RAW.
  assign VSR1 = (commit && (sr1 == dr)) ? dr_in : rf_rd1;
  assign VSR2 = (commit && (sr2 == dr)) ? dr_in : rf_rd2;
`else
  assign VSR1 = rf_rd1;
  assign VSR2 = rf_rd2;
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Directed and pseudo-random bench for lc3_writeback with an architectural
// register/NZP model checked every negedge.
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [1:0]  W_Control = 2'd3;
  logic [15:0] aluout = '0, pcout = '0, memout = '0;
  logic [2:0]  dr = '0, sr1 = '0, sr2 = '0;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;

  int total = 0;
  int bad   = 0;

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .pcout            (pcout),
    .memout           (memout),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Architectural model
  logic [15:0] m_regs [8];
  logic [2:0]  m_psr;
  bit          m_valid = 0;

  function automatic logic [15:0] m_sel();
    if (W_Control == 2'd1) return memout;
    if (W_Control == 2'd2) return pcout;
    return aluout;
  endfunction

  function automatic bit m_commit();
    return enable_writeback && (W_Control != 2'd3);
  endfunction

  function automatic logic [2:0] m_cc(input logic [15:0] v);
    if (v == 16'h0000) return 3'b010;
    if (v >= 16'h8000) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] s);
`ifdef LC3_WRITEBACK_BYPASS_EN
    if (m_commit() && s == dr) return m_sel();
`endif
    return m_regs[s];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
      m_psr   <= 3'b000;
      m_valid <= 1;
    end else if (m_commit()) begin
      m_regs[dr] <= m_sel();
      m_psr      <= m_cc(m_sel());
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_vsr1", VSR1, m_read(sr1));
      check("model_vsr2", VSR2, m_read(sr2));
      check("model_psr", {13'd0, psr}, {13'd0, m_psr});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] exp_byp;

  initial begin
    // Reset for two cycles, then sweep reads
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(7 - i);
      @(negedge clock);
      check("reset_vsr1", VSR1, 16'h0000);
      check("reset_vsr2", VSR2, 16'h0000);
      check("reset_psr", {13'd0, psr}, 16'h0000);
      #1;
    end

    // Source select
    dr = 3'd3; sr1 = 3'd3; enable_writeback = 1'b1;
    aluout = 16'h1234; memout = 16'hBEEF; pcout = 16'h3000;
    W_Control = 2'd0; tick();
    check("sel_alu", VSR1, 16'h1234);
    check("sel_alu_psr", {13'd0, psr}, 16'h0001);
    W_Control = 2'd1; tick();
    check("sel_mem", VSR1, 16'hBEEF);
    check("sel_mem_psr", {13'd0, psr}, 16'h0004);
    W_Control = 2'd2; tick();
    check("sel_pc", VSR1, 16'h3000);
    check("sel_pc_psr", {13'd0, psr}, 16'h0001);

    // Zero result, then no-write encodings
    dr = 3'd5; sr1 = 3'd5; aluout = 16'h0000; W_Control = 2'd0; tick();
    check("zero_psr", {13'd0, psr}, 16'h0002);
    check("zero_r5", VSR1, 16'h0000);
    W_Control = 2'd3; aluout = 16'hFFFF; tick();
    check("nowrite_r5", VSR1, 16'h0000);
    check("nowrite_psr", {13'd0, psr}, 16'h0002);
    enable_writeback = 1'b0; W_Control = 2'd0; tick();
    check("disabled_r5", VSR1, 16'h0000);
    check("disabled_psr", {13'd0, psr}, 16'h0002);

    // Reset collides with a commit
    enable_writeback = 1'b1; W_Control = 2'd0; dr = 3'd2; sr1 = 3'd2;
    aluout = 16'h5555; reset = 1'b1; tick();
    reset = 1'b0; enable_writeback = 1'b0; #1;
    check("collide_r2", VSR1, 16'h0000);
    check("collide_psr", {13'd0, psr}, 16'h0000);
    check("collide_r3", m_regs[3], 16'h0000);

    // Same-cycle read of the destination
    enable_writeback = 1'b1; W_Control = 2'd0; dr = 3'd4; aluout = 16'h0001; tick();
    aluout = 16'h00AA; sr1 = 3'd4; #1;
`ifdef LC3_WRITEBACK_BYPASS_EN
    exp_byp = 16'h00AA;
`else
    exp_byp = 16'h0001;
`endif
    check("bypass_same", VSR1, exp_byp);
    tick();
    enable_writeback = 1'b0; #1;
    check("bypass_next", VSR1, 16'h00AA);

    // Back-to-back writes to R7
    enable_writeback = 1'b1; dr = 3'd7; sr2 = 3'd7; aluout = 16'h8000; tick();
    check("b2b_psr1", {13'd0, psr}, 16'h0004);
    aluout = 16'h0007; tick();
    check("b2b_psr2", {13'd0, psr}, 16'h0001);
    enable_writeback = 1'b0; #1;
    check("b2b_r7", VSR2, 16'h0007);

    // Pseudo-random traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      enable_writeback = ($urandom_range(0, 3) != 0);
      W_Control = 2'($urandom_range(0, 3));
      aluout = 16'($urandom);
      memout = 16'($urandom);
      pcout  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      dr  = 3'($urandom_range(0, 7));
      sr1 = ($urandom_range(0, 2) == 0) ? dr : 3'($urandom_range(0, 7));
      sr2 = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; enable_writeback = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
# lc3_writeback

Final stage of the LC3 microcontroller pipeline. It owns the eight 16-bit general-purpose registers and the NZP condition-code register. It commits the result that Execute and Memory hand forward (aluout, pcout or memout) into register dr. It is also the responder for Execute's operand requests: sr1/sr2 in, VSR1/VSR2 out, read asynchronously.

## Interface
Parameters:
- none; widths are fixed by the LC3 ISA (16-bit data, 3-bit register index).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- enable_writeback  in  1  commit strobe; no architectural state changes when low.
- W_Control  in  2  result source select: 0 = aluout, 1 = memout, 2 = pcout, 3 = no write.
- aluout  in  16  ALU result from Execute.
- pcout  in  16  computed address from Execute (LEA).
- memout  in  16  data read from memory (LD/LDR/LDI).
- dr  in  3  destination register index.
- sr1  in  3  source index 1 from Execute.
- sr2  in  3  source index 2 from Execute.
- VSR1  out  16  contents of R[sr1], combinational.
- VSR2  out  16  contents of R[sr2], combinational.
- psr  out  3  condition codes {N,Z,P}, registered.

## Operation
- DR_in is the selected write value, chosen by W_Control: aluout, memout or pcout.
- Commit condition: enable_writeback=1 and W_Control≠3. When it holds, at posedge:
  - R[dr] ← DR_in.
  - psr ← {DR_in[15], DR_in==0, ~DR_in[15] & DR_in≠0}. Exactly one psr bit is set after any commit.
- When enable_writeback=1 and W_Control=3: register file and psr are held.
- When enable_writeback=0: register file and psr are held, regardless of W_Control.
- Reads:
  - VSR1 = R[sr1] and VSR2 = R[sr2], through a pure combinational path (no clock).
  - sr1==sr2 is legal; both outputs carry the same value.
- Reset, synchronous: all R0–R7 ← 16'h0000 and psr ← 3'b000.
  - Reset wins over a commit in the same cycle.
  - Reset asserted mid-stream discards the in-flight commit.
  - VSR1/VSR2 read 0 from the cycle after the reset edge.
- Unknown W_Control (X) is a verification error. The RTL does not have to handle it.

## Timing
- Write latency: 1 cycle. The value is visible in R[dr] and psr after the posedge on which the commit condition was true.
- Read latency: 0 cycles, combinational from sr1/sr2 and register state.
- Same-cycle read of dr during a commit: the result depends on configuration (see below).
- Back-to-back commits to the same dr on consecutive cycles: the last write wins. psr tracks each write.
- There is no handshake or backpressure. Execute and Memory sequence enable_writeback.

## Configuration
- Macro: LC3_WRITEBACK_BYPASS_EN.
- Defined: write-through bypass. If the commit condition holds and sr1==dr, VSR1=DR_in in the same cycle; the same rule applies to sr2/VSR2. This removes one hazard stall in the controller.
- Not defined: read-before-write. VSR1/VSR2 return the old R[sr] during the commit cycle. The controller must stall one cycle on a RAW hazard.
- psr behaviour is identical in both builds (always registered).

## Structure
- Shared package lc3_pkg:
  - W_Control encodings: WB_ALU=2'd0, WB_MEM=2'd1, WB_PC=2'd2, WB_NONE=2'd3.
  - PSR bit indices: PSR_N=2, PSR_Z=1, PSR_P=0.
  - LC3_NREGS=8 and LC3_DW=16.
- One sub-module, lc3_regfile: 8×16 storage with one synchronous write port, two asynchronous read ports and synchronous reset.
- The mux, psr logic and bypass logic live in lc3_writeback.

## Test plan
- Reset then reads: assert reset for 2 cycles, sweep sr1/sr2 over 0–7 → VSR1=VSR2=16'h0000 and psr=3'b000.
- Source select: dr=3, enable_writeback=1, aluout=16'h1234, memout=16'hBEEF, pcout=16'h3000, step W_Control through 0,1,2 on successive cycles with sr1=3 → VSR1 reads 16'h1234, 16'hBEEF, 16'h3000; psr reads 001, 100, 001.
- Zero / no-write: commit aluout=16'h0000 to R5 → psr=3'b010. Then W_Control=3 with aluout=16'hFFFF → R5 stays 0 and psr stays 010. Then enable_writeback=0 with W_Control=0 → no change.
- Reset collision: reset=1 and a commit to R2 of 16'h5555 on the same edge → R2=0 and psr=000.
- Bypass: sr1=dr=4, R4=16'h0001, commit 16'h00AA → the same-cycle VSR1 is 16'h00AA with LC3_WRITEBACK_BYPASS_EN and 16'h0001 without it. Both builds read 16'h00AA on the next cycle.
- Back-to-back: commit 16'h8000 then 16'h0007 to R7 on consecutive cycles → R7=16'h0007, psr sequence 100 then 001.
